// File: rtl/slice_pkg.sv
// rtl/slice_pkg.sv - shared widths, FSM encoding and arithmetic helpers for the slice accumulator
package slice_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int COEF_W_DEF = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN
    } slice_state_t;

    // Largest positive value of a w-bit two's-complement number
    function automatic logic [63:0] full_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative value of a w-bit two's-complement number (low w bits)
    function automatic logic [63:0] full_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

    // Replicate bit w-1 of v into every bit above it
    function automatic logic [63:0] sign_ext(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = v;
        for (int i = 0; i < 64; i++) begin
            if (i >= w) r[i] = v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_slice_accumulator_if.sv
// rtl/sd_slice_accumulator_if.sv - control, coefficient, logging and status bundle of the slice accumulator
interface sd_slice_accumulator_if #(
    parameter int CHANNELS = 16,
    parameter int DATA_W   = 24,
    parameter int COEF_W   = 18,
    parameter int ADR_W    = $clog2(CHANNELS)
);
    logic                  slice_enable;
    logic                  start;
    logic                  clear_state;
    logic [CHANNELS-1:0]   sigma_delta_stream_A;
    logic [CHANNELS-1:0]   sigma_delta_stream_B;
    logic [ADR_W-1:0]      coefficient_write_adr;
    logic [2*COEF_W-1:0]   coefficient_write_data;
    logic                  coefficient_write_en;
    logic [ADR_W-1:0]      log_adr;
    logic                  log_trigger;
    logic                  busy;
    logic                  done;
    logic                  overflow_stage_1;
    logic                  overflow_stage_2;
    logic [DATA_W-1:0]     log_value_out;

    modport master (
        output slice_enable, start, clear_state, sigma_delta_stream_A, sigma_delta_stream_B,
               coefficient_write_adr, coefficient_write_data, coefficient_write_en,
               log_adr, log_trigger,
        input  busy, done, overflow_stage_1, overflow_stage_2, log_value_out
    );

    modport slave (
        input  slice_enable, start, clear_state, sigma_delta_stream_A, sigma_delta_stream_B,
               coefficient_write_adr, coefficient_write_data, coefficient_write_en,
               log_adr, log_trigger,
        output busy, done, overflow_stage_1, overflow_stage_2, log_value_out
    );
endinterface

// File: rtl/sd_addsub_stage.sv
// rtl/sd_addsub_stage.sv - signed add/sub with overflow detect; clamps when SLICE_SATURATE_EN is defined
module sd_addsub_stage
    import slice_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit REGISTERED = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    input  logic                     i_add,
    output logic signed [DATA_W-1:0] o_result,
    output logic                     o_ovf
);
`ifdef SLICE_SATURATE_EN
    localparam logic [DATA_W-1:0] FULL_POS = DATA_W'(full_pos(DATA_W));
    localparam logic [DATA_W-1:0] FULL_NEG = DATA_W'(full_neg(DATA_W));
`endif

    logic signed [DATA_W-1:0] w_raw;
    logic signed [DATA_W-1:0] w_res;
    logic                     w_ovf;

    // Overflow: effective operand signs agree but the result sign differs from i_a
    always_comb begin
        w_raw = i_add ? (i_a + i_b) : (i_a - i_b);
        w_ovf = (i_add ? (i_a[DATA_W-1] == i_b[DATA_W-1]) : (i_a[DATA_W-1] != i_b[DATA_W-1]))
                && (w_raw[DATA_W-1] != i_a[DATA_W-1]);
`ifdef SLICE_SATURATE_EN
        w_res = w_ovf ? (i_a[DATA_W-1] ? FULL_NEG : FULL_POS) : w_raw;
`else
        w_res = w_raw;
`endif
    end

    generate
        if (REGISTERED) begin : g_reg
            logic signed [DATA_W-1:0] r_result;
            logic                     r_ovf;

            // Output register, held while the slice clock enable is low
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_result <= '0;
                    r_ovf    <= 1'b0;
                end else if (i_en) begin
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                end
            end

            assign o_result = r_result;
            assign o_ovf    = r_ovf;
        end else begin : g_comb
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, i_en};
            assign o_result = w_res;
            assign o_ovf    = w_ovf;
        end
    endgenerate
endmodule

// File: rtl/sd_slice_accumulator.sv
// rtl/sd_slice_accumulator.sv - multi-channel sigma-delta slice accumulator; saturation via SLICE_SATURATE_EN
module sd_slice_accumulator
    import slice_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int COEF_W   = COEF_W_DEF,
    parameter int CHANNELS = 16,
    parameter int ADR_W    = $clog2(CHANNELS)
) (
    input logic                   clock_200,
    input logic                   reset,
    sd_slice_accumulator_if.slave bus
);
    logic [DATA_W-1:0]   r_state_ram [CHANNELS];
    logic [2*COEF_W-1:0] r_coef_ram  [CHANNELS];

    slice_state_t        r_state;
    logic [ADR_W-1:0]    r_k;
    logic                r_drain;
    logic                r_busy;
    logic                r_done;
    logic                r_ovf1;
    logic                r_ovf2;
    logic                r_clear;
    logic [CHANNELS-1:0] r_stream_a;
    logic [CHANNELS-1:0] r_stream_b;

    logic                r_v1;
    logic [ADR_W-1:0]    r_a1;
    logic                r_v2;
    logic [ADR_W-1:0]    r_a2;
    logic [DATA_W-1:0]   r_state_q;
    logic [2*COEF_W-1:0] r_coef_q;

    logic                r_log_v;
    logic [DATA_W-1:0]   r_log_q;
    logic [DATA_W-1:0]   r_log_out;

    logic                     w_en;
    logic [COEF_W-1:0]        w_coef_a_raw;
    logic [COEF_W-1:0]        w_coef_b_raw;
    logic signed [DATA_W-1:0] w_coef_a;
    logic signed [DATA_W-1:0] w_coef_b;
    logic signed [DATA_W-1:0] w_s1;
    logic signed [DATA_W-1:0] w_s2;
    logic                     w_ovf1;
    logic                     w_ovf2;
    logic [DATA_W-1:0]        w_wb_data;

    assign w_en         = bus.slice_enable;
    assign w_coef_a_raw = r_coef_q[2*COEF_W-1:COEF_W];
    assign w_coef_b_raw = r_coef_q[COEF_W-1:0];
    assign w_coef_a     = DATA_W'(sign_ext(64'(w_coef_a_raw), COEF_W));
    assign w_coef_b     = DATA_W'(sign_ext(64'(w_coef_b_raw), COEF_W));
    assign w_wb_data    = r_clear ? '0 : w_s2;

    sd_addsub_stage #(.DATA_W(DATA_W), .REGISTERED(1'b0)) u_stage1 (
        .clk      (clock_200),
        .rst      (reset),
        .i_en     (w_en),
        .i_a      (r_state_q),
        .i_b      (w_coef_a),
        .i_add    (r_stream_a[r_a1]),
        .o_result (w_s1),
        .o_ovf    (w_ovf1)
    );

    sd_addsub_stage #(.DATA_W(DATA_W), .REGISTERED(1'b1)) u_stage2 (
        .clk      (clock_200),
        .rst      (reset),
        .i_en     (w_en),
        .i_a      (w_s1),
        .i_b      (w_coef_b),
        .i_add    (r_stream_b[r_a1]),
        .o_result (w_s2),
        .o_ovf    (w_ovf2)
    );

    // Sweep control: accept start, walk the channel index, drain the pipe, pulse done
    always_ff @(posedge clock_200 or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_drain    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf1     <= 1'b0;
            r_ovf2     <= 1'b0;
            r_clear    <= 1'b0;
            r_stream_a <= '0;
            r_stream_b <= '0;
        end else if (w_en) begin
            r_done <= 1'b0;
            if (r_v1 && !r_clear && w_ovf1) r_ovf1 <= 1'b1;
            if (r_v2 && !r_clear && w_ovf2) r_ovf2 <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    // busy covers the done cycle, so start is still refused there
                    if (r_done) r_busy <= 1'b0;
                    if (bus.start && !r_busy) begin
                        r_state    <= ST_SWEEP;
                        r_k        <= '0;
                        r_busy     <= 1'b1;
                        r_ovf1     <= 1'b0;
                        r_ovf2     <= 1'b0;
                        r_clear    <= bus.clear_state;
                        r_stream_a <= bus.sigma_delta_stream_A;
                        r_stream_b <= bus.sigma_delta_stream_B;
                    end
                end
                ST_SWEEP: begin
                    r_k <= r_k + ADR_W'(1);
                    if (r_k == ADR_W'(CHANNELS - 1)) begin
                        r_state <= ST_DRAIN;
                        r_drain <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read pipeline: RAM outputs and channel tags follow the address by one and two cycles
    always_ff @(posedge clock_200 or posedge reset) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_a1      <= '0;
            r_v2      <= 1'b0;
            r_a2      <= '0;
            r_state_q <= '0;
            r_coef_q  <= '0;
        end else if (w_en) begin
            r_v1      <= (r_state == ST_SWEEP);
            r_a1      <= r_k;
            r_v2      <= r_v1;
            r_a2      <= r_a1;
            r_state_q <= r_state_ram[r_k];
            r_coef_q  <= r_coef_ram[r_k];
        end
    end

    // Log port: second state read, then the output register
    always_ff @(posedge clock_200 or posedge reset) begin
        if (reset) begin
            r_log_v   <= 1'b0;
            r_log_q   <= '0;
            r_log_out <= '0;
        end else if (w_en) begin
            r_log_v <= bus.log_trigger;
            r_log_q <= r_state_ram[bus.log_adr];
            if (r_log_v) r_log_out <= r_log_q;
        end
    end

    // RAM writes; contents are not reset, software clears them with a clear_state sweep
    always_ff @(posedge clock_200) begin
        if (w_en && r_v2) r_state_ram[r_a2] <= w_wb_data;
        if (w_en && bus.coefficient_write_en) r_coef_ram[bus.coefficient_write_adr] <= bus.coefficient_write_data;
    end

    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.overflow_stage_1 = r_ovf1;
    assign bus.overflow_stage_2 = r_ovf2;
    assign bus.log_value_out    = r_log_out;
endmodule

// File: tb/tb_sd_slice_accumulator.sv
// tb/tb_sd_slice_accumulator.sv - randomized self-checking bench for sd_slice_accumulator
`timescale 1ns/1ps
module tb_sd_slice_accumulator;
    localparam int CH = 16;
    localparam int DW = 24;
    localparam int CW = 18;
    localparam int AW = 4;
    localparam longint MAXV = 8388607;
    localparam longint MINV = -8388608;
`ifdef SLICE_SATURATE_EN
    localparam longint OVF_EXP = 8388607;
`else
    localparam longint OVF_EXP = -8388509;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #2.5 clk = ~clk;

    sd_slice_accumulator_if #(.CHANNELS(CH), .DATA_W(DW), .COEF_W(CW), .ADR_W(AW)) bus ();

    sd_slice_accumulator #(.DATA_W(DW), .COEF_W(CW), .CHANNELS(CH), .ADR_W(AW)) dut (
        .clock_200 (clk),
        .reset     (rst),
        .bus       (bus)
    );

    longint m_st [CH];
    longint m_ca [CH];
    longint m_cb [CH];
    bit     m_f1, m_f2;
    int     n_checks = 0;
    int     n_fail   = 0;

    function automatic longint wrap_w(input longint v);
        longint m;
        m = v & ((64'sd1 <<< DW) - 1);
        if (m > MAXV) m = m - (64'sd1 <<< DW);
        return m;
    endfunction

    function automatic longint stage_op(input longint a, input longint b, input bit add, output bit ovf);
        longint r;
        r = add ? a + b : a - b;
        ovf = (r > MAXV) || (r < MINV);
`ifdef SLICE_SATURATE_EN
        if (r > MAXV) r = MAXV;
        else if (r < MINV) r = MINV;
`else
        r = wrap_w(r);
`endif
        return r;
    endfunction

    function automatic void model_sweep(input bit clr, input logic [CH-1:0] sa, input logic [CH-1:0] sb);
        longint s1, s2;
        bit o1, o2;
        m_f1 = 1'b0;
        m_f2 = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (clr) begin
                m_st[k] = 0;
            end else begin
                s1 = stage_op(m_st[k], m_ca[k], sa[k], o1);
                s2 = stage_op(s1, m_cb[k], sb[k], o2);
                m_f1 = m_f1 | o1;
                m_f2 = m_f2 | o2;
                m_st[k] = s2;
            end
        end
    endfunction

    task automatic write_coef(input int adr, input longint a, input longint b);
        @(negedge clk);
        bus.coefficient_write_adr  = AW'(adr);
        bus.coefficient_write_data = {CW'(a), CW'(b)};
        bus.coefficient_write_en   = 1'b1;
        @(negedge clk);
        bus.coefficient_write_en   = 1'b0;
        m_ca[adr] = a;
        m_cb[adr] = b;
    endtask

    task automatic read_log(input int adr, output longint v);
        @(negedge clk);
        bus.log_adr     = AW'(adr);
        bus.log_trigger = 1'b1;
        @(negedge clk);
        bus.log_trigger = 1'b0;
        @(negedge clk);
        v = longint'($signed(bus.log_value_out));
    endtask

    task automatic do_sweep(input bit clr, input logic [CH-1:0] sa, input logic [CH-1:0] sb,
                            input int stall_at, input int stall_len,
                            input int cw_cyc, input int cw_adr, input longint cw_a, input longint cw_b,
                            input int restart_cyc,
                            output int busy_cnt, output int done_at, output int done_cnt);
        busy_cnt = 0;
        done_at  = -1;
        done_cnt = 0;
        @(negedge clk);
        bus.slice_enable         = 1'b1;
        bus.start                = 1'b1;
        bus.clear_state          = clr;
        bus.sigma_delta_stream_A = sa;
        bus.sigma_delta_stream_B = sb;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            bus.start                  = (c == restart_cyc);
            bus.slice_enable           = !(c >= stall_at && c < stall_at + stall_len);
            bus.coefficient_write_en   = (c == cw_cyc);
            bus.coefficient_write_adr  = AW'(cw_adr);
            bus.coefficient_write_data = {CW'(cw_a), CW'(cw_b)};
            if (done_at >= 0 && c >= done_at + 3) break;
        end
        bus.start                = 1'b0;
        bus.slice_enable         = 1'b1;
        bus.coefficient_write_en = 1'b0;
        bus.sigma_delta_stream_A = CH'($urandom);
        bus.sigma_delta_stream_B = CH'($urandom);
    endtask

    task automatic test_reset();
        bus.slice_enable = 1'b1; bus.start = 1'b0; bus.clear_state = 1'b0;
        bus.sigma_delta_stream_A = '0; bus.sigma_delta_stream_B = '0;
        bus.coefficient_write_adr = '0; bus.coefficient_write_data = '0; bus.coefficient_write_en = 1'b0;
        bus.log_adr = '0; bus.log_trigger = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        if (bus.overflow_stage_1 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf1: got %b expected 0", bus.overflow_stage_1); end
        if (bus.overflow_stage_2 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf2: got %b expected 0", bus.overflow_stage_2); end
        if (bus.log_value_out !== '0) begin n_fail++; $display("FAIL reset_log: got %0d expected 0", bus.log_value_out); end
        rst = 1'b0;
        for (int i = 0; i < CH; i++) write_coef(i, 0, 0);
    endtask

    task automatic test_clear();
        int bc, da, dc;
        longint v;
        do_sweep(1'b1, '1, '1, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b1, '1, '1);
        n_checks += 4;
        if (bc !== 19) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 19", bc); end
        if (da !== CH + 2) begin n_fail++; $display("FAIL clear_done_cycle: got %0d expected %0d", da, CH + 2); end
        if (dc !== 1) begin n_fail++; $display("FAIL clear_done_pulses: got %0d expected 1", dc); end
        if (bus.overflow_stage_1 !== 1'b0 || bus.overflow_stage_2 !== 1'b0) begin
            n_fail++; $display("FAIL clear_flags: got %b%b expected 00", bus.overflow_stage_1, bus.overflow_stage_2);
        end
        for (int i = 0; i < CH; i++) begin
            read_log(i, v);
            n_checks++;
            if (v !== 0) begin n_fail++; $display("FAIL clear_ch%0d: got %0d expected 0", i, v); end
        end
    endtask

    task automatic test_basic();
        int bc, da, dc;
        longint v;
        logic [CH-1:0] sa, sb;
        write_coef(0, 9485, 0);
        for (int i = 1; i < CH; i++) write_coef(i, longint'($urandom_range(4000)) - 2000, longint'($urandom_range(4000)) - 2000);
        do_sweep(1'b0, '1, '1, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b0, '1, '1);
        write_coef(0, -7343, 2394);
        sa = CH'($urandom) | CH'(1);
        sb = CH'($urandom) & ~CH'(1);
        do_sweep(1'b0, sa, sb, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b0, sa, sb);
        n_checks += 2;
        if (da !== CH + 2) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", da, CH + 2); end
        if (bus.overflow_stage_1 !== 1'b0 || bus.overflow_stage_2 !== 1'b0) begin
            n_fail++; $display("FAIL basic_flags: got %b%b expected 00", bus.overflow_stage_1, bus.overflow_stage_2);
        end
        read_log(0, v);
        n_checks++;
        if (v !== -252) begin n_fail++; $display("FAIL basic_ch0: got %0d expected -252", v); end
        for (int i = 1; i < CH; i++) begin
            read_log(i, v);
            n_checks++;
            if (v !== m_st[i]) begin n_fail++; $display("FAIL basic_ch%0d: got %0d expected %0d", i, v, m_st[i]); end
        end
    endtask

    task automatic test_full_sweep();
        int bc, da, dc;
        longint v;
        logic [CH-1:0] sa, sb;
        for (int i = 0; i < CH; i++) write_coef(i, longint'($urandom_range(262143)) - 131072, longint'($urandom_range(262143)) - 131072);
        sa = CH'($urandom);
        sb = CH'($urandom);
        do_sweep(1'b0, sa, sb, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b0, sa, sb);
        n_checks += 3;
        if (bc !== 19) begin n_fail++; $display("FAIL full_busy_cycles: got %0d expected 19", bc); end
        if (bus.overflow_stage_1 !== m_f1) begin n_fail++; $display("FAIL full_ovf1: got %b expected %b", bus.overflow_stage_1, m_f1); end
        if (bus.overflow_stage_2 !== m_f2) begin n_fail++; $display("FAIL full_ovf2: got %b expected %b", bus.overflow_stage_2, m_f2); end
        for (int i = 0; i < CH; i++) begin
            read_log(i, v);
            n_checks++;
            if (v !== m_st[i]) begin n_fail++; $display("FAIL full_ch%0d: got %0d expected %0d", i, v, m_st[i]); end
        end
    endtask

    task automatic test_overflow();
        int bc, da, dc;
        longint v;
        logic [CH-1:0] sb;
        do_sweep(1'b1, '1, '1, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b1, '1, '1);
        for (int i = 1; i < CH; i++) write_coef(i, 0, 0);
        write_coef(0, 131071, 131071);
        for (int n = 0; n < 32; n++) begin
            do_sweep(1'b0, '1, '1, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
            model_sweep(1'b0, '1, '1);
        end
        write_coef(0, 63, 0);
        do_sweep(1'b0, '1, '1, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b0, '1, '1);
        read_log(0, v);
        n_checks++;
        if (v !== MAXV) begin n_fail++; $display("FAIL ovf_ramp_ch0: got %0d expected %0d", v, MAXV); end
        write_coef(0, 100, 0);
        do_sweep(1'b0, '1, '1, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b0, '1, '1);
        n_checks += 3;
        if (bus.overflow_stage_1 !== 1'b1) begin n_fail++; $display("FAIL ovf_stage1_flag: got %b expected 1", bus.overflow_stage_1); end
        if (bus.overflow_stage_2 !== 1'b0) begin n_fail++; $display("FAIL ovf_stage2_quiet: got %b expected 0", bus.overflow_stage_2); end
        read_log(0, v);
        if (v !== OVF_EXP) begin n_fail++; $display("FAIL ovf_result_ch0: got %0d expected %0d", v, OVF_EXP); end
        write_coef(0, 0, 200);
        sb = '1;
        sb[0] = (m_st[0] > 0);
        do_sweep(1'b0, '1, sb, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b0, '1, sb);
        n_checks += 3;
        if (bus.overflow_stage_1 !== 1'b0) begin n_fail++; $display("FAIL ovf2_stage1_quiet: got %b expected 0", bus.overflow_stage_1); end
        if (bus.overflow_stage_2 !== 1'b1) begin n_fail++; $display("FAIL ovf2_stage2_flag: got %b expected 1", bus.overflow_stage_2); end
        read_log(0, v);
        if (v !== m_st[0]) begin n_fail++; $display("FAIL ovf2_result_ch0: got %0d expected %0d", v, m_st[0]); end
    endtask

    task automatic test_reset_mid();
        int bc, da, dc;
        longint v;
        write_coef(0, (m_st[0] > 0) ? 131071 : -131071, 0);
        read_log(0, v);
        n_checks++;
        if (v !== m_st[0]) begin n_fail++; $display("FAIL rstmid_prelog: got %0d expected %0d", v, m_st[0]); end
        @(negedge clk);
        bus.start = 1'b1;
        bus.clear_state = 1'b0;
        bus.sigma_delta_stream_A = '1;
        bus.sigma_delta_stream_B = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_checks += 2;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", bus.busy); end
        if (bus.overflow_stage_1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_ovf1_before: got %b expected 1", bus.overflow_stage_1); end
        rst = 1'b1;
        #1;
        n_checks += 5;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
        if (bus.overflow_stage_1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf1: got %b expected 0", bus.overflow_stage_1); end
        if (bus.overflow_stage_2 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf2: got %b expected 0", bus.overflow_stage_2); end
        if (bus.log_value_out !== '0) begin n_fail++; $display("FAIL rstmid_log: got %0d expected 0", bus.log_value_out); end
        @(negedge clk);
        rst = 1'b0;
        do_sweep(1'b1, '1, '1, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b1, '1, '1);
        n_checks++;
        if (da !== CH + 2) begin n_fail++; $display("FAIL rstmid_restart_done: got %0d expected %0d", da, CH + 2); end
        for (int i = 0; i < CH; i++) begin
            read_log(i, v);
            n_checks++;
            if (v !== 0) begin n_fail++; $display("FAIL rstmid_clear_ch%0d: got %0d expected 0", i, v); end
        end
    endtask

    task automatic test_stall();
        int bc, da, dc;
        longint v;
        logic [CH-1:0] sa, sb;
        for (int i = 0; i < CH; i++) write_coef(i, longint'($urandom_range(262143)) - 131072, longint'($urandom_range(262143)) - 131072);
        sa = CH'($urandom);
        sb = CH'($urandom);
        do_sweep(1'b0, sa, sb, 8, 5, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b0, sa, sb);
        n_checks += 3;
        if (da !== CH + 2 + 5) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected %0d", da, CH + 7); end
        if (bc !== 24) begin n_fail++; $display("FAIL stall_busy_cycles: got %0d expected 24", bc); end
        if (dc !== 1) begin n_fail++; $display("FAIL stall_done_pulses: got %0d expected 1", dc); end
        for (int i = 0; i < CH; i++) begin
            read_log(i, v);
            n_checks++;
            if (v !== m_st[i]) begin n_fail++; $display("FAIL stall_ch%0d: got %0d expected %0d", i, v, m_st[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int bc, da, dc;
        longint v, na, nb;
        logic [CH-1:0] sa, sb;
        for (int i = 0; i < CH; i++) write_coef(i, longint'($urandom_range(262143)) - 131072, longint'($urandom_range(262143)) - 131072);
        na = longint'($urandom_range(262143)) - 131072;
        nb = longint'($urandom_range(262143)) - 131072;
        sa = CH'($urandom);
        sb = CH'($urandom);
        do_sweep(1'b0, sa, sb, -1, 0, 3, 3, na, nb, 5, bc, da, dc);
        model_sweep(1'b0, sa, sb);
        m_ca[3] = na;
        m_cb[3] = nb;
        n_checks += 3;
        if (bc !== 19) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 19", bc); end
        if (dc !== 1) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d expected 1", dc); end
        if (da !== CH + 2) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d expected %0d", da, CH + 2); end
        for (int i = 0; i < CH; i++) begin
            read_log(i, v);
            n_checks++;
            if (v !== m_st[i]) begin n_fail++; $display("FAIL b2b_first_ch%0d: got %0d expected %0d", i, v, m_st[i]); end
        end
        do_sweep(1'b0, sa, sb, -1, 0, -1, 0, 0, 0, -1, bc, da, dc);
        model_sweep(1'b0, sa, sb);
        for (int i = 0; i < CH; i++) begin
            read_log(i, v);
            n_checks++;
            if (v !== m_st[i]) begin n_fail++; $display("FAIL b2b_second_ch%0d: got %0d expected %0d", i, v, m_st[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_basic();
        test_full_sweep();
        test_overflow();
        test_reset_mid();
        test_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
